binary_decoder_3_seq: RTL

- Sequential 3-to-8 binary decoder, the decode-side counterpart of the team's 3-bit binary encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives a registered one-hot 8-bit output for a programmable number of cycles.
- Inserts an optional blanking gap after each code and counts decoded codes.
- Feeds LED / display-select logic in the lab designs.

---
 rtl/binary_decoder_3_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/binary_decoder_3_seq.sv
// Sequential 3-to-8 binary decoder: accepts a code over valid/ready, shows it
// one-hot for HOLD_CYCLES cycles, blanks for GAP_CYCLES, and counts accepts.
module binary_decoder_3_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic [7:0]       y,
  output logic             y_valid,
  output logic             busy,
  output logic [CNT_W-1:0] dec_count
);

  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       y_q, y_d;
  logic             y_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Ready depends only on registered state and en, never on in_valid.
  assign in_ready = en && (state_q == IDLE);

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    y_d     = y_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = SHOW;
          timer_d = HOLD_LOAD;
          y_d     = 8'd1 << in_code;
          count_d = count_q + CNT_W'(1);
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          y_d     = 8'd0;
        end else if (timer_q == '0) begin
          y_d = 8'd0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (!en || timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = 8'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      y_q       <= 8'd0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      y_q       <= y_d;
      y_valid_q <= (y_d != 8'd0);
      busy_q    <= (state_d != IDLE);
      count_q   <= count_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign busy      = busy_q;
  assign dec_count = count_q;

endmodule
